vector_deserializer: RTL and testbench
======================================

VECTOR_DESERIALIZER -- requirements
Module: vector_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 17, giving the sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter INPUT_SIZE, default 32, giving the vector length (>=1) presented to the downstream adder tree.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = in reset).
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning in_data holds a sample.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits signed, the sample value.
REQ-008 The block SHALL have port in_last, input, 1 bit, marking the final sample of a short vector.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds a complete vector.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the vector.
REQ-011 The block SHALL have port out_data, output, unpacked array [INPUT_SIZE] of WIDTH-bit signed values, the assembled vector, element 0 being the first sample.
REQ-012 The block SHALL have port out_count, output, $clog2(INPUT_SIZE+1) bits, the number of samples accepted into the current vector.

Function
REQ-013 The block SHALL implement a two-state FSM: FILL (collecting) and HOLD (vector presented).
REQ-014 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1; both outputs are decoded from registered state only.
REQ-015 A sample SHALL be accepted when in_valid and in_ready are both 1 on a rising edge; it is written to out_data[out_count] and out_count increments by 1.
REQ-016 When the accepted sample has out_count == INPUT_SIZE-1 (buffer becomes full) or in_last == 1, the FSM SHALL move to HOLD on that same edge, so out_valid is 1 in the next cycle (latency of 1 cycle from final accept).
REQ-017 Elements never written in the current vector SHALL read as zero, so a short vector sums correctly in the adder tree.
REQ-018 in_last SHALL be ignored unless the sample is accepted; in_last on a full-buffer sample SHALL behave identically to a full buffer.
REQ-019 In HOLD, out_data and out_count SHALL remain stable until a handshake (out_valid and out_ready both 1) occurs.
REQ-020 On the HOLD handshake edge, the FSM SHALL return to FILL, out_count SHALL become 0, and every out_data element SHALL become 0; no sample is accepted on that edge (in_ready was 0).
REQ-021 in_valid and in_data in HOLD SHALL be ignored and produce no state change; the upstream must hold the sample until in_ready returns.
REQ-022 out_ready in FILL SHALL be ignored.
REQ-023 Minimum vector period SHALL be N+1 cycles for an N-sample vector (N accept cycles plus one HOLD handshake cycle).
REQ-024 With INPUT_SIZE == 1, every accepted sample SHALL complete a vector.

Reset
REQ-025 While reset == 0, the FSM SHALL be in FILL, out_count SHALL be 0, every out_data element SHALL be 0, out_valid SHALL be 0 and in_ready SHALL be 1, independent of clk.
REQ-026 Assertion of reset mid-FILL or mid-HOLD SHALL discard the partial or held vector with no out_valid pulse; the first accept after release is written to element 0.

Verification
REQ-027 Full vector: 32 back-to-back samples 1..32, in_last=0, out_ready=1 -> out_valid high the cycle after 32nd accept, out_data[k]=k+1, out_count=32, one cycle of HOLD, then in_ready=1.
REQ-028 Short vector: samples 5, -3, 7 with in_last on 7 -> out_data = {5,-3,7,0,...,0}, out_count=3; adder tree fed with out_data yields sum 9.
REQ-029 Backpressure: out_ready=0 for 10 cycles in HOLD while in_valid=1, in_data=99 -> out_data, out_count unchanged, in_ready=0 throughout, 99 not written; after out_ready=1, next vector begins with 99 at element 0.
REQ-030 Gapped input: in_valid toggling 1/0 over 8 samples -10..-3 with in_last on last -> only valid cycles accepted, out_count=8, out_data[0]=-10, out_data[7]=-3, remaining 24 elements zero.
REQ-031 Reset mid-fill: reset low after 12 accepts, released, then 32 samples of value 2 -> no out_valid before the 32nd accept; out_data all 2, out_count=32.
REQ-032 Boundary values: samples 65535 and -65536 (WIDTH 17 extremes) with in_last on second -> out_data[0]=65535, out_data[1]=-65536 stored bit-exact, out_count=2.

Source files
------------

// File: rtl/vector_deserializer.sv
// Collects a stream of signed samples into a zero-padded vector for an adder tree.
// A vector closes on a full buffer or an accepted in_last and is held until taken.
module vector_deserializer #(
    parameter int WIDTH      = 17,
    parameter int INPUT_SIZE = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data [INPUT_SIZE],
    output logic [$clog2(INPUT_SIZE+1)-1:0] out_count
);

    localparam int CW = $clog2(INPUT_SIZE + 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic signed [WIDTH-1:0] data_q [INPUT_SIZE];
    logic signed [WIDTH-1:0] data_d [INPUT_SIZE];

    logic accept;
    logic full;

    assign accept = in_valid && (state_q == FILL);
    assign full   = (count_q == CW'(INPUT_SIZE - 1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        if (accept) begin
            for (int i = 0; i < INPUT_SIZE; i++) begin
                if (count_q == CW'(i)) begin
                    data_d[i] = in_data;
                end
            end
            count_d = count_q + CW'(1);
            if (full || in_last) begin
                state_d = HOLD;
            end
        end else if ((state_q == HOLD) && out_ready) begin
            // Clearing on release keeps unwritten slots of the next short vector at zero.
            state_d = FILL;
            count_d = '0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                data_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            count_q <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_count = count_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_vector_deserializer.sv
// Directed bench for vector_deserializer with WIDTH=17, INPUT_SIZE=32.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_vector_deserializer;

    localparam int W = 17;
    localparam int N = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_data = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] out_data [N];
    logic [5:0]          out_count;

    int checks   = 0;
    int failures = 0;
    int n;
    int sum;
    bit early;

    vector_deserializer #(.WIDTH(W), .INPUT_SIZE(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Number of elements in [lo, N) that differ from val.
    task automatic count_ne(input int lo, input int val, output int cnt);
        cnt = 0;
        for (int i = lo; i < N; i++) begin
            if (int'(out_data[i]) != val) cnt++;
        end
    endtask

    task automatic handshake();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state, checked with no clock edge dependence
        #3;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(out_count), 0);
        count_ne(0, 0, n);
        chk("rst_data_nonzero", n, 0);
        step();
        reset = 1'b1;

        // Full vector 1..32 with out_ready high throughout
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid = 1'b1;
            in_data  = W'(k + 1);
            step();
            if (k == N - 2) chk("full_no_early_valid", int'(out_valid), 0);
        end
        in_valid = 1'b0;
        chk("full_out_valid", int'(out_valid), 1);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_count", int'(out_count), 32);
        n = 0;
        for (int i = 0; i < N; i++) if (int'(out_data[i]) != i + 1) n++;
        chk("full_data_mismatch", n, 0);
        step();
        chk("full_release_in_ready", int'(in_ready), 1);
        chk("full_release_count", int'(out_count), 0);
        chk("full_release_d0", int'(out_data[0]), 0);
        out_ready = 1'b0;

        // Short vector 5, -3, 7
        in_valid = 1'b1;
        in_data = 17'sd5;  step();
        in_data = -17'sd3; step();
        in_data = 17'sd7;  in_last = 1'b1; step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("short_out_valid", int'(out_valid), 1);
        chk("short_count", int'(out_count), 3);
        chk("short_d0", int'(out_data[0]), 5);
        chk("short_d1", int'(out_data[1]), -3);
        chk("short_d2", int'(out_data[2]), 7);
        count_ne(3, 0, n);
        chk("short_tail_nonzero", n, 0);
        sum = 0;
        for (int i = 0; i < N; i++) sum += int'(out_data[i]);
        chk("short_sum", sum, 9);
        handshake();

        // Backpressure: vector {1,2} held while upstream offers 99
        in_valid = 1'b1;
        in_data = 17'sd1; step();
        in_data = 17'sd2; in_last = 1'b1; step();
        in_data = 17'sd99; in_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_count", int'(out_count), 2);
            chk("bp_d0", int'(out_data[0]) + int'(out_data[1]) * 1000, 2001);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_count", int'(out_count), 0);
        chk("bp_release_d0", int'(out_data[0]), 0);
        in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_next_count", int'(out_count), 1);
        chk("bp_next_d0", int'(out_data[0]), 99);
        chk("bp_next_valid", int'(out_valid), 1);
        handshake();

        // Gapped input -10..-3; in_last raised on idle cycles must be ignored
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i - 10);
            in_last  = (i == 7);
            step();
            in_valid = 1'b0;
            in_last  = 1'b1;
            if (i == 3) chk("gap_mid_count", int'(out_count), 4);
            step();
        end
        in_last = 1'b0;
        chk("gap_out_valid", int'(out_valid), 1);
        chk("gap_count", int'(out_count), 8);
        chk("gap_d0", int'(out_data[0]), -10);
        chk("gap_d7", int'(out_data[7]), -3);
        count_ne(8, 0, n);
        chk("gap_tail_nonzero", n, 0);
        handshake();

        // Reset after 12 accepts, then 32 samples of 2
        in_valid = 1'b1;
        in_data  = 17'sd7;
        for (int i = 0; i < 12; i++) step();
        in_valid = 1'b0;
        reset = 1'b0;
        #2;
        chk("midfill_rst_count", int'(out_count), 0);
        chk("midfill_rst_d0", int'(out_data[0]), 0);
        reset = 1'b1;
        step();
        early = 1'b0;
        in_valid = 1'b1;
        in_data  = 17'sd2;
        for (int i = 0; i < N; i++) begin
            if (out_valid) early = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("midfill_early_valid", int'(early), 0);
        chk("midfill_out_valid", int'(out_valid), 1);
        chk("midfill_count", int'(out_count), 32);
        count_ne(0, 2, n);
        chk("midfill_data_ne2", n, 0);
        handshake();

        // Extremes 65535, -65536, then reset while holding
        in_valid = 1'b1;
        in_data = 17'sd65535;  step();
        in_data = -17'sd65536; in_last = 1'b1; step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("edge_count", int'(out_count), 2);
        chk("edge_d0", int'(out_data[0]), 65535);
        chk("edge_d1", int'(out_data[1]), -65536);
        chk("edge_d1_bits", int'(out_data[1][16:0]), 65536);
        reset = 1'b0;
        #2;
        chk("hold_rst_valid", int'(out_valid), 0);
        chk("hold_rst_in_ready", int'(in_ready), 1);
        chk("hold_rst_count", int'(out_count), 0);
        chk("hold_rst_d0", int'(out_data[0]), 0);
        reset = 1'b1;
        step();
        in_valid = 1'b1;
        in_data  = 17'sd4;
        step();
        in_valid = 1'b0;
        chk("post_rst_d0", int'(out_data[0]), 4);
        chk("post_rst_count", int'(out_count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
